// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, bubble encoding and defaults for the pipeline registers
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic valid;
    } ifid_t;
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: generic pipeline register; reset/clear load CLR_VAL, enable loads d, otherwise hold
module pipe_reg #(
    parameter int W = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (reset || clear) ? CLR_VAL : en ? d : q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register with redirect/stall handling and the IF/ID pipeline register
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);
    logic [XLEN-1:0] pc_plus;
    ifid_t ifid_d, ifid_q;
    assign pc_plus = pc_f + PC_STEP;
    assign imem_addr = pc_f;
    // a redirect wins over a stall or a memory wait so a taken branch is never dropped
    always_ff @(posedge clk)
        pc_f <= reset ? RESET_PC
              : pc_src_e ? pc_target_e
              : (stall_f || !imem_ready) ? pc_f
              : pc_plus;
    assign ifid_d = '{instr: imem_rdata, pc: pc_f, pc_plus4: pc_plus, valid: 1'b1};
    // flush beats stall; a memory wait only bubbles IF/ID when decode is not holding
    pipe_reg #(.W($bits(ifid_t)), .CLR_VAL(IFID_BUBBLE)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .clear (flush_d || (!stall_d && !imem_ready)),
        .en    (!stall_d),
        .d     (ifid_d),
        .q     (ifid_q)
    );
    assign instr_d = ifid_q.instr;
    assign pc_d = ifid_q.pc;
    assign pc_plus4_d = ifid_q.pc_plus4;
    assign valid_d = ifid_q.valid;
endmodule
